ps2_key_event_queue: RTL and testbench

Parametrised PS/2 scan-code set 2 decoder that turns a raw keyboard byte stream into a live key-state bitmap and a buffered queue of make/break events. Sits between the PS/2 byte receiver and the application logic (text editor, game FSMs). Replaces polling of a single last-change register with a valid/ready event FIFO, so no keystroke is lost when the consumer is busy.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/sync_fifo_fwft.sv | 50 +++++
 rtl/ps2_key_event_queue.sv | 136 +++++++++++++
 tb/tb_ps2_key_event_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code set 2 constants, decoder states and the queued event format.
package ps2_pkg;

  localparam logic [7:0] PS2_BAT = 8'hAA;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [2:0] {
    StWaitBat,
    StIdle,
    StGotE0,
    StGotF0,
    StGotE0F0
  } ps2_state_e;

  typedef struct packed {
    logic       brk;
    logic [8:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head data is valid whenever empty is low.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/ps2_key_event_queue.sv
// PS/2 set 2 decoder: keeps a live key-state bitmap and queues make/break events
// in a FWFT FIFO so a busy consumer never misses a keystroke.
module ps2_key_event_queue
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter bit          FILTER_REPEAT = 1'b1,
  parameter bit          REQUIRE_BAT   = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  input  logic         byte_err,
  output logic [511:0] key_down,
  output logic [9:0]   keys_held,
  output logic         kb_ready,
  output logic         evt_valid,
  output logic [8:0]   evt_code,
  output logic         evt_break,
  input  logic         evt_ready,
  output logic         overflow,
  input  logic         clr_overflow
);

  ps2_state_e   state_q, state_d;
  logic [511:0] key_down_q, key_down_d;
  logic [9:0]   keys_held_q, keys_held_d;
  logic         overflow_q, overflow_d;

  logic         dec_fire, dec_brk, hot_clear;
  logic [8:0]   dec_code;
  logic         key_changes, evt_push, fifo_full, fifo_empty;
  ps2_evt_t     fifo_head;

  always_comb begin
    state_d   = state_q;
    dec_fire  = 1'b0;
    dec_brk   = 1'b0;
    dec_code  = '0;
    hot_clear = 1'b0;
    if (byte_err && state_q != StWaitBat) begin
      state_d = StIdle;
    end else if (byte_valid) begin
      unique case (state_q)
        StWaitBat: if (byte_in == PS2_BAT) state_d = StIdle;
        StIdle: begin
          if (byte_in == PS2_EXT)      state_d = StGotE0;
          else if (byte_in == PS2_BRK) state_d = StGotF0;
          else if (byte_in == PS2_BAT) hot_clear = 1'b1;
          else begin
            dec_fire = 1'b1;
            dec_code = {1'b0, byte_in};
          end
        end
        StGotE0: begin
          if (byte_in == PS2_BRK) state_d = StGotE0F0;
          else if (byte_in != PS2_EXT) begin
            state_d  = StIdle;
            dec_fire = 1'b1;
            dec_code = {1'b1, byte_in};
          end
        end
        StGotF0, StGotE0F0: begin
          state_d = StIdle;
          // A prefix byte here is a protocol error: the sequence is dropped.
          if (byte_in != PS2_EXT && byte_in != PS2_BRK) begin
            dec_fire = 1'b1;
            dec_brk  = 1'b1;
            dec_code = {state_q == StGotE0F0, byte_in};
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Make changes the bitmap only if the key was up, break only if it was down.
  assign key_changes = dec_fire && (key_down_q[dec_code] == dec_brk);
  assign evt_push    = dec_fire && (!FILTER_REPEAT || key_changes);

  always_comb begin
    key_down_d  = key_down_q;
    keys_held_d = keys_held_q;
    if (hot_clear) begin
      key_down_d  = '0;
      keys_held_d = '0;
    end else if (key_changes) begin
      key_down_d[dec_code] = ~dec_brk;
      keys_held_d = dec_brk ? keys_held_q - 10'd1 : keys_held_q + 10'd1;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (evt_push && fifo_full && !(evt_ready && !fifo_empty)) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= REQUIRE_BAT ? StWaitBat : StIdle;
      key_down_q  <= '0;
      keys_held_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_down_q  <= key_down_d;
      keys_held_q <= keys_held_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH($bits(ps2_evt_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (evt_push),
    .din  ({dec_brk, dec_code}),
    .pop  (evt_ready),
    .dout (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign key_down  = key_down_q;
  assign keys_held = keys_held_q;
  assign kb_ready  = (state_q != StWaitBat);
  assign evt_valid = ~fifo_empty;
  assign evt_code  = fifo_head.code;
  assign evt_break = fifo_head.brk;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench: default-parameter DUT plus a FILTER_REPEAT=0/REQUIRE_BAT=0 DUT on shared inputs.
module tb_ps2_key_event_queue;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   byte_in = '0;
  logic         byte_valid = 1'b0;
  logic         byte_err = 1'b0;
  logic         evt_ready = 1'b0;
  logic         clr_overflow = 1'b0;

  logic [511:0] key_down, key_down2;
  logic [9:0]   keys_held, keys_held2;
  logic         kb_ready, kb_ready2;
  logic         evt_valid, evt_valid2;
  logic [8:0]   evt_code, evt_code2;
  logic         evt_break, evt_break2;
  logic         overflow, overflow2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ps2_key_event_queue u_dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_err(byte_err),
    .key_down(key_down), .keys_held(keys_held), .kb_ready(kb_ready), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_break(evt_break), .evt_ready(evt_ready), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  ps2_key_event_queue #(.FIFO_DEPTH(8), .FILTER_REPEAT(1'b0), .REQUIRE_BAT(1'b0)) u_dut_nf (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .byte_err(byte_err),
    .key_down(key_down2), .keys_held(keys_held2), .kb_ready(kb_ready2), .evt_valid(evt_valid2),
    .evt_code(evt_code2), .evt_break(evt_break2), .evt_ready(evt_ready), .overflow(overflow2),
    .clr_overflow(clr_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  task automatic do_reset(input bit send_bat);
    byte_valid = 1'b0; byte_err = 1'b0; evt_ready = 1'b0; clr_overflow = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    if (send_bat) send_byte(8'hAA);
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    total++; if (key_down !== '0) begin bad++; $display("FAIL reset_key_down got=%h", key_down); end
    total++; if (keys_held !== 10'd0) begin bad++; $display("FAIL reset_keys_held got=%0d want=0", keys_held); end
    total++; if (kb_ready !== 1'b0) begin bad++; $display("FAIL reset_kb_ready got=%b want=0", kb_ready); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_evt_valid got=%b want=0", evt_valid); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (kb_ready2 !== 1'b1) begin bad++; $display("FAIL reset_kb_ready_nobat got=%b want=1", kb_ready2); end
  endtask

  task automatic test_bat();
    send_byte(8'h1C);
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL bat_prebyte_ignored got=%b want=0", evt_valid); end
    send_byte(8'hAA);
    total++; if (kb_ready !== 1'b1) begin bad++; $display("FAIL bat_kb_ready got=%b want=1", kb_ready); end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL bat_no_event got=%b want=0", evt_valid); end
    send_byte(8'h1C);
    total++; if ({evt_valid, evt_break, evt_code} !== {1'b1, 1'b0, 9'h01C}) begin
      bad++; $display("FAIL bat_make got v=%b b=%b c=%h want v=1 b=0 c=01c", evt_valid, evt_break, evt_code);
    end
    total++; if (key_down[9'h01C] !== 1'b1 || keys_held !== 10'd1) begin
      bad++; $display("FAIL bat_keymap got bit=%b held=%0d want bit=1 held=1", key_down[9'h01C], keys_held);
    end
    pop_one();
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL bat_pop got=%b want=0", evt_valid); end
  endtask

  task automatic test_extended();
    do_reset(1'b1);
    send_byte(8'hE0); send_byte(8'h75);
    total++; if ({evt_valid, evt_break, evt_code} !== {1'b1, 1'b0, 9'h175}) begin
      bad++; $display("FAIL ext_make got v=%b b=%b c=%h want v=1 b=0 c=175", evt_valid, evt_break, evt_code);
    end
    total++; if (key_down[9'h175] !== 1'b1 || keys_held !== 10'd1) begin
      bad++; $display("FAIL ext_make_map got bit=%b held=%0d want bit=1 held=1", key_down[9'h175], keys_held);
    end
    pop_one();
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    total++; if ({evt_valid, evt_break, evt_code} !== {1'b1, 1'b1, 9'h175}) begin
      bad++; $display("FAIL ext_break got v=%b b=%b c=%h want v=1 b=1 c=175", evt_valid, evt_break, evt_code);
    end
    total++; if (key_down[9'h175] !== 1'b0 || keys_held !== 10'd0) begin
      bad++; $display("FAIL ext_break_map got bit=%b held=%0d want bit=0 held=0", key_down[9'h175], keys_held);
    end
    pop_one();
  endtask

  task automatic test_typematic();
    logic [7:0] seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    int n1 = 0;
    int n2 = 0;
    do_reset(1'b1);
    foreach (seq[i]) send_byte(seq[i]);
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (evt_valid)  n1++;
      if (evt_valid2) n2++;
      tick();
    end
    evt_ready = 1'b0;
    total++; if (n1 != 2) begin bad++; $display("FAIL typematic_filtered got=%0d want=2", n1); end
    total++; if (n2 != 4) begin bad++; $display("FAIL typematic_unfiltered got=%0d want=4", n2); end
    total++; if (keys_held !== 10'd0) begin bad++; $display("FAIL typematic_held got=%0d want=0", keys_held); end
  endtask

  task automatic test_backpressure();
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL bp_overflow got=%b want=1", overflow); end
    total++; if (keys_held !== 10'd9 || key_down[9'h018] !== 1'b1) begin
      bad++; $display("FAIL bp_keymap got held=%0d bit18=%b want held=9 bit18=1", keys_held, key_down[9'h018]);
    end
    total++; if (evt_valid !== 1'b1 || evt_code !== 9'h010) begin
      bad++; $display("FAIL bp_head got v=%b c=%h want v=1 c=010", evt_valid, evt_code);
    end
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_clr got=%b want=0", overflow); end
    // Full FIFO: pop 0x10 and push 0x19 on the same edge.
    evt_ready = 1'b1;
    send_byte(8'h19);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL bp_pushpop_overflow got=%b want=0", overflow); end
    for (int i = 0; i < 8; i++) begin
      logic [8:0] want;
      want = (i < 7) ? 9'h011 + 9'(i) : 9'h019;
      total++; if (evt_valid !== 1'b1 || evt_code !== want) begin
        bad++; $display("FAIL bp_drain%0d got v=%b c=%h want v=1 c=%h", i, evt_valid, evt_code, want);
      end
      tick();
    end
    evt_ready = 1'b0;
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", evt_valid); end
  endtask

  task automatic test_error_hotplug();
    do_reset(1'b1);
    send_byte(8'hE0); send_byte(8'hF0);
    byte_err = 1'b1;
    tick();
    byte_err = 1'b0;
    send_byte(8'h75);
    total++; if ({evt_valid, evt_break, evt_code} !== {1'b1, 1'b0, 9'h075}) begin
      bad++; $display("FAIL err_make got v=%b b=%b c=%h want v=1 b=0 c=075", evt_valid, evt_break, evt_code);
    end
    pop_one();
    send_byte(8'hAA);
    total++; if (key_down !== '0 || keys_held !== 10'd0) begin
      bad++; $display("FAIL hotplug_clear got held=%0d want=0", keys_held);
    end
    total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL hotplug_no_event got=%b want=0", evt_valid); end
  endtask

  task automatic test_async_rst();
    do_reset(1'b1);
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23);
    send_byte(8'hE0);
    #3 rst = 1'b1;
    #1;
    total++; if (evt_valid !== 1'b0 || key_down !== '0 || keys_held !== 10'd0) begin
      bad++; $display("FAIL arst_clear got v=%b held=%0d want v=0 held=0", evt_valid, keys_held);
    end
    total++; if (kb_ready !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL arst_flags got rdy=%b ovf=%b want 0 0", kb_ready, overflow);
    end
    tick();
    rst = 1'b0;
    send_byte(8'hAA); send_byte(8'h1C);
    total++; if ({evt_valid, evt_break, evt_code} !== {1'b1, 1'b0, 9'h01C}) begin
      bad++; $display("FAIL arst_resume got v=%b b=%b c=%h want v=1 b=0 c=01c", evt_valid, evt_break, evt_code);
    end
  endtask

  initial begin
    test_reset();
    test_bat();
    test_extended();
    test_typematic();
    test_backpressure();
    test_error_hotplug();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
